// File: rtl/ula_pkg.sv
// Shared ALU types: operand width, opcode enum and the request payload queued ahead of the ALU.
package ula_pkg;

    localparam int unsigned W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } ula_op_e;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        ula_op_e      op;
    } ula_req_t;

endpackage

// File: rtl/ula_seq_if.sv
// Request and result valid/ready channels of the ALU sequencer.
interface ula_seq_if
    import ula_pkg::*;
();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    ula_op_e      in_op;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    ula_op_e      out_op;
    logic         out_zero;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero
    );

endinterface

// File: rtl/ula.sv
// Combinational 8-bit ALU; carry and borrow are dropped.
module ula
    import ula_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  ula_op_e      op,
    output logic [W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ula_fifo.sv
// Register-array FIFO; pushes when full and pops when empty are ignored.
module ula_fifo
    import ula_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = ula_req_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  T                       wdata,
    output T                       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (fill == (PTR_W+1)'(DEPTH));
    assign empty   = (fill == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   fill <= fill + (PTR_W+1)'(1);
                2'b01:   fill <= fill - (PTR_W+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Queues ALU requests, presents the head to the ALU and registers its result into a held output slot.
module ula_seq
    import ula_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ula_seq_if.slave               bus,
    output logic [W-1:0]           alu_a,
    output logic [W-1:0]           alu_b,
    output ula_op_e                alu_op,
    input  logic [W-1:0]           alu_result,
    output logic [$clog2(DEPTH):0] fill
);

    ula_req_t wr_req;
    ula_req_t head;
    logic     full;
    logic     empty;
    logic     push;
    logic     fire;

    assign wr_req      = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
    assign bus.in_ready = !full;
    assign push        = bus.in_valid && !full;
    // Issue whenever the slot is free or being emptied this cycle.
    assign fire        = !empty && (!bus.out_valid || bus.out_ready);

    ula_fifo #(
        .DEPTH (DEPTH),
        .T     (ula_req_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (fire),
        .wdata (wr_req),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
        if (!empty) begin
            alu_a  = head.a;
            alu_b  = head.b;
            alu_op = head.op;
        end
    end

    // Output slot: load on issue, clear valid on a plain drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_op     <= OP_ADD;
            bus.out_zero   <= 1'b0;
        end else if (fire) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= alu_result;
            bus.out_op     <= head.op;
            bus.out_zero   <= (alu_result == '0);
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Directed and random checks of ula_seq driving a real ula against a queue-based reference model.
module tb_ula_seq;
    import ula_pkg::*;

    typedef struct {
        logic [7:0] r;
        ula_op_e    op;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    ula_op_e    alu_op;
    logic [2:0] fill;

    int         errors = 0;
    int         checks = 0;
    exp_t       q[$];
    logic [7:0] last_res = 8'h00;

    always #5 clk = ~clk;

    ula_seq_if bus ();

    ula_seq #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .fill       (fill)
    );

    ula u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    function automatic logic [7:0] ref_op(input int a, input int b, input ula_op_e op);
        int r;
        case (op)
            OP_ADD:  r = (a + b) % 256;
            OP_SUB:  r = (a - b + 256) % 256;
            OP_AND:  r = a & b;
            default: r = a | b;
        endcase
        return 8'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, settle, consume/accept in the model, then take the edge.
    task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input ula_op_e op, input logic ordy);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid && ordy) begin
            chk("result_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_result", 32'(bus.out_result), 32'(e.r));
                chk("out_op", 32'(bus.out_op), 32'(e.op));
                chk("out_zero", 32'(bus.out_zero), 32'(e.r == 8'h00));
                last_res = e.r;
            end
        end
        if (iv && bus.in_ready) q.push_back('{ref_op(int'(a), int'(b), op), op});
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand(input logic iv, input logic ordy);
        step(iv, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             ula_op_e'(2'($urandom_range(0, 3))), ordy);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 8'hAA;
        bus.in_b      = 8'h55;
        bus.in_op     = OP_OR;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // Single op with latency check
        step(1'b1, 8'h0F, 8'h01, OP_ADD, 1'b1);
        chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
        chk("lat_fill", 32'(fill), 32'd1);
        chk("lat_alu_a", 32'(alu_a), 32'h0F);
        step(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("single_result", 32'(bus.out_result), 32'h10);
        chk("single_zero", 32'(bus.out_zero), 32'd0);
        step(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);

        // Wrap-around add and borrow on subtract
        step(1'b1, 8'hFF, 8'h01, OP_ADD, 1'b1);
        step(1'b1, 8'h00, 8'h01, OP_SUB, 1'b1);
        chk("wrap_result", 32'(bus.out_result), 32'h00);
        chk("wrap_zero", 32'(bus.out_zero), 32'd1);
        step(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);
        chk("borrow_result", 32'(bus.out_result), 32'hFF);
        chk("borrow_zero", 32'(bus.out_zero), 32'd0);
        repeat (2) step(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);
        chk("drain_hold", 32'(bus.out_result), 32'(last_res));
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // Back-pressure until the FIFO is full
        step(1'b1, 8'hF0, 8'h3C, OP_AND, 1'b0);
        step(1'b1, 8'hF0, 8'h3C, OP_OR, 1'b0);
        repeat (3) step_rand(1'b1, 1'b0);
        chk("bp_fill", 32'(fill), 32'd4);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_slot", 32'(bus.out_result), 32'h30);
        chk("bp_head_a", 32'(alu_a), 32'hF0);
        chk("bp_head_op", 32'(alu_op), 32'(OP_OR));
        step_rand(1'b1, 1'b0);
        chk("bp_full_hold", 32'(fill), 32'd4);
        chk("bp_stall_result", 32'(bus.out_result), 32'h30);
        repeat (6) step(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);
        chk("bp_all_out", 32'(q.size()), 32'd0);
        chk("bp_fill_empty", 32'(fill), 32'd0);
        chk("bp_drain_valid", 32'(bus.out_valid), 32'd0);

        // Streaming at one result per cycle
        for (int i = 0; i < 16; i++) begin
            step_rand(1'b1, 1'b1);
            if (i >= 1) begin
                chk("stream_valid", 32'(bus.out_valid), 32'd1);
                chk("stream_fill", 32'(fill), 32'd1);
            end
        end
        repeat (3) step(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);
        chk("stream_all_out", 32'(q.size()), 32'd0);

        // Asynchronous reset while busy
        repeat (4) step_rand(1'b1, 1'b0);
        chk("mid_fill", 32'(fill), 32'd3);
        chk("mid_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_fill", 32'(fill), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_result", 32'(bus.out_result), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);
            chk("post_rst_stale", 32'(bus.out_valid), 32'd0);
        end
        step(1'b1, 8'h12, 8'h21, OP_OR, 1'b1);
        repeat (3) step(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);
        chk("post_rst_all_out", 32'(q.size()), 32'd0);
        chk("post_rst_last", 32'(last_res), 32'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
